// File: rtl/riscv_core_pkg.sv
// riscv_core_pkg: shared constants and enums for the execute-stage divider
package riscv_core_pkg;
   localparam int XLEN = 64;
   typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_e;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;
endpackage

// File: rtl/riscv_core_div.sv
// riscv_core_div: iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W forms
module riscv_core_div #(
   parameter int XLEN = 64
) (
   input  logic            i_div_clk,
   input  logic            i_div_rst,
   input  logic            i_div_start,
   input  logic            i_div_kill,
   input  logic [1:0]      i_div_op,
   input  logic            i_div_word,
   input  logic [XLEN-1:0] i_div_a,
   input  logic [XLEN-1:0] i_div_b,
   input  logic [4:0]      i_div_rd,
   output logic            o_div_busy,
   output logic            o_div_done,
   output logic [XLEN-1:0] o_div_result,
   output logic [4:0]      o_div_rd
);
   import riscv_core_pkg::*;
   div_state_e state;
   div_op_e op_q;
   logic word_q, sa_q, sb_q, spec_q;
   logic [6:0] cnt;
   logic [63:0] q, d, r;
   logic sgn, sa, sb, div0, ovf, is_rem;
   logic [63:0] a_s, b_s, abs_a, abs_b, a_res, spec_res, qv, res, fin;
   logic [64:0] rs, trial;
   assign sgn = ~i_div_op[0];
   // W forms sign-extend only for signed ops so unsigned W operands stay positive
   assign a_s = i_div_word ? {{32{sgn & i_div_a[31]}}, i_div_a[31:0]} : i_div_a;
   assign b_s = i_div_word ? {{32{sgn & i_div_b[31]}}, i_div_b[31:0]} : i_div_b;
   assign sa = sgn & a_s[63];
   assign sb = sgn & b_s[63];
   assign abs_a = sa ? -a_s : a_s;
   assign abs_b = sb ? -b_s : b_s;
   assign div0 = ~|b_s;
   assign ovf = sgn & (i_div_word ? (i_div_a[31:0] == 32'h8000_0000 && &i_div_b[31:0])
                                  : (i_div_a == {1'b1, 63'b0} && &i_div_b));
   assign a_res = i_div_word ? {{32{i_div_a[31]}}, i_div_a[31:0]} : i_div_a;
   assign spec_res = i_div_op[1] ? (div0 ? a_res : '0) : (div0 ? '1 : a_res);
   assign rs = {r, q[63]};
   assign trial = rs - {1'b0, d};
   assign is_rem = (op_q == REM) || (op_q == REMU);
   assign qv = word_q ? {32'b0, q[31:0]} : q;
   assign res = spec_q ? q : is_rem ? (sa_q ? -r : r) : ((sa_q ^ sb_q) ? -qv : qv);
   assign fin = word_q ? {{32{res[31]}}, res[31:0]} : res;
   always_ff @(posedge i_div_clk) begin
      if (i_div_rst) begin
         state <= IDLE;
         o_div_busy <= 1'b0;
         o_div_done <= 1'b0;
         o_div_result <= '0;
         o_div_rd <= '0;
      end else if (i_div_kill) begin
         state <= IDLE;
         o_div_busy <= 1'b0;
         o_div_done <= 1'b0;
      end else begin
         case (state)
            IDLE: if (i_div_start) begin
               op_q <= div_op_e'(i_div_op);
               word_q <= i_div_word;
               sa_q <= sa;
               sb_q <= sb;
               spec_q <= div0 | ovf;
               d <= abs_b;
               r <= '0;
               // W dividends are left-aligned so 32 steps consume exactly their bits
               q <= (div0 | ovf) ? spec_res : i_div_word ? {abs_a[31:0], 32'b0} : abs_a;
               cnt <= i_div_word ? 7'd31 : 7'd63;
               o_div_rd <= i_div_rd;
               o_div_busy <= 1'b1;
               state <= (div0 | ovf) ? FIX : CALC;
            end
            CALC: begin
               r <= trial[64] ? rs[63:0] : trial[63:0];
               q <= {q[62:0], ~trial[64]};
               cnt <= cnt - 7'd1;
               state <= (cnt == 7'd0) ? FIX : CALC;
            end
            FIX: begin
               o_div_result <= fin;
               o_div_done <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               o_div_done <= 1'b0;
               o_div_busy <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_riscv_core_div.sv
// tb_riscv_core_div: directed and random checks of riscv_core_div against an arithmetic model
module tb_riscv_core_div;
   logic clk, rst, start, kill, word, busy, done;
   logic [1:0] op;
   logic [63:0] a, b, result;
   logic [4:0] rd, rd_o;
   int n_assert, n_fail;

   riscv_core_div dut (
      .i_div_clk(clk), .i_div_rst(rst), .i_div_start(start), .i_div_kill(kill),
      .i_div_op(op), .i_div_word(word), .i_div_a(a), .i_div_b(b), .i_div_rd(rd),
      .o_div_busy(busy), .o_div_done(done), .o_div_result(result), .o_div_rd(rd_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] m_op, input logic m_w,
                                         input logic [63:0] m_a, input logic [63:0] m_b);
      logic sg, rm;
      logic [31:0] a32, b32, q32, r32;
      logic [63:0] q64, r64;
      sg = ~m_op[0];
      rm = m_op[1];
      a32 = m_a[31:0];
      b32 = m_b[31:0];
      if (m_w) begin
         if (b32 == 0) begin q32 = '1; r32 = a32; end
         else if (sg && a32 == 32'h8000_0000 && b32 == '1) begin q32 = a32; r32 = '0; end
         else if (sg) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
         else begin q32 = a32 / b32; r32 = a32 % b32; end
         return rm ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
      end
      if (m_b == 0) begin q64 = '1; r64 = m_a; end
      else if (sg && m_a == 64'h8000_0000_0000_0000 && m_b == '1) begin q64 = m_a; r64 = '0; end
      else if (sg) begin q64 = $signed(m_a) / $signed(m_b); r64 = $signed(m_a) % $signed(m_b); end
      else begin q64 = m_a / m_b; r64 = m_a % m_b; end
      return rm ? r64 : q64;
   endfunction

   function automatic int lat_of(input logic [1:0] m_op, input logic m_w,
                                 input logic [63:0] m_a, input logic [63:0] m_b);
      logic sg;
      sg = ~m_op[0];
      if (m_w)
         return (m_b[31:0] == 0 || (sg && m_a[31:0] == 32'h8000_0000 && m_b[31:0] == '1)) ? 2 : 34;
      return (m_b == 0 || (sg && m_a == 64'h8000_0000_0000_0000 && m_b == '1)) ? 2 : 66;
   endfunction

   task automatic go(input logic [1:0] t_op, input logic t_w, input logic [63:0] t_a,
                     input logic [63:0] t_b, input logic [4:0] t_rd);
      start = 1'b1; op = t_op; word = t_w; a = t_a; b = t_b; rd = t_rd;
   endtask

   task automatic finish_op(input logic [63:0] exp, input int lat, input logic [4:0] exp_rd);
      int k;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_accept", 64'(busy), 64'd1);
      k = 1;
      while (!done && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      check("done_seen", 64'(done), 64'd1);
      check("latency", 64'(k), 64'(lat));
      check("result", result, exp);
      check("rd", 64'(rd_o), 64'(exp_rd));
      @(posedge clk); #1;
      check("done_one_cycle", 64'(done), 64'd0);
      check("idle_after_done", 64'(busy), 64'd0);
      check("result_hold", result, exp);
   endtask

   task automatic run(input logic [1:0] t_op, input logic t_w, input logic [63:0] t_a,
                      input logic [63:0] t_b, input logic [4:0] t_rd);
      @(posedge clk); #1;
      go(t_op, t_w, t_a, t_b, t_rd);
      finish_op(model(t_op, t_w, t_a, t_b), lat_of(t_op, t_w, t_a, t_b), t_rd);
   endtask

   initial begin
      logic seen;
      logic [1:0] r_op;
      logic r_w;
      logic [63:0] r_a, r_b;
      n_assert = 0;
      n_fail = 0;
      rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'd0; word = 1'b0; a = '0; b = '0; rd = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_result", result, 64'd0);
      check("reset_rd", 64'(rd_o), 64'd0);
      rst = 1'b0;
      run(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3);
      check("div_neg7_by_2", result, 64'hFFFF_FFFF_FFFF_FFFD);
      run(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4);
      check("rem_neg7_by_2", result, 64'hFFFF_FFFF_FFFF_FFFF);
      run(2'b11, 1'b0, 64'h1234, 64'd0, 5'd5);
      check("remu_by_zero", result, 64'h1234);
      run(2'b01, 1'b0, 64'h1234, 64'd0, 5'd6);
      check("divu_by_zero", result, 64'hFFFF_FFFF_FFFF_FFFF);
      run(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7);
      check("div_overflow", result, 64'h8000_0000_0000_0000);
      run(2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8);
      check("rem_overflow", result, 64'd0);
      run(2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 5'd9);
      check("divuw", result, 64'h0000_0000_7FFF_FFFF);
      run(2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd12);
      check("divw_overflow", result, 64'hFFFF_FFFF_8000_0000);
      check("divw_rd12", 64'(rd_o), 64'd12);
      // kill in cycle 10, then restart in cycle 11
      @(posedge clk); #1;
      go(2'b01, 1'b0, 64'd100, 64'd7, 5'd1);
      @(posedge clk); #1;
      start = 1'b0;
      seen = 1'b0;
      repeat (9) begin
         seen |= done;
         @(posedge clk); #1;
      end
      seen |= done;
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      check("kill_busy", 64'(busy), 64'd0);
      check("kill_no_done", 64'(seen | done), 64'd0);
      go(2'b01, 1'b0, 64'd100, 64'd7, 5'd2);
      finish_op(64'd14, 66, 5'd2);
      // reset in cycle 20 of an operation
      @(posedge clk); #1;
      go(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_result", result, 64'd0);
      seen = 1'b0;
      repeat (70) begin
         @(posedge clk); #1;
         seen |= done | busy;
      end
      check("midrst_quiet", 64'(seen), 64'd0);
      // start together with kill is refused
      go(2'b01, 1'b0, 64'd100, 64'd7, 5'd9);
      kill = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      kill = 1'b0;
      check("startkill_busy", 64'(busy), 64'd0);
      seen = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         seen |= done | busy;
      end
      check("startkill_quiet", 64'(seen), 64'd0);
      for (int i = 0; i < 40; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_w = 1'($urandom_range(0, 1));
         r_a = {$urandom, $urandom};
         r_b = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: r_b = r_w ? {$urandom, 32'h0} : 64'd0;
            1: r_b = r_w ? {$urandom, 32'(1 + $urandom_range(0, 20))} : 64'(1 + $urandom_range(0, 20));
            2: begin
               r_a = r_w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
               r_b = r_w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
            end
            3: r_a = 64'($urandom_range(0, 1000));
            default: ;
         endcase
         run(r_op, r_w, r_a, r_b, 5'($urandom_range(0, 31)));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
